// File: rtl/bcd_binary_serial.sv
// Two-digit BCD to 7-bit binary converter, serial reverse double-dabble.
// Seven shift/adjust iterations per request, with start/busy/done handshake and digit error flag.
module bcd_binary_serial (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [3:0] tens_in,
    input  logic [3:0] ones_in,
    output logic       busy,
    output logic       done,
    output logic       error,
    output logic [6:0] binary_out
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] DONE  = 2'd2;

    localparam logic [2:0] LAST_ITER = 3'd6;

    logic [1:0]  state;
    logic [7:0]  bcd_sr;
    logic [6:0]  bin_sr;
    logic [2:0]  iter_cnt;

    logic [14:0] shifted;
    logic [7:0]  bcd_adj;
    logic [6:0]  bin_next;
    logic        digits_valid;

    // A nibble that is 8 or more after the right shift held a 10 before it; take 3 off.
    function automatic logic [3:0] adjust(input logic [3:0] nibble);
        logic [3:0] result;
        result = nibble;
        if (nibble >= 4'd8) begin
            result = nibble - 4'd3;
        end
        return result;
    endfunction

    always_comb begin
        shifted      = {bcd_sr, bin_sr} >> 1;
        bcd_adj      = {adjust(shifted[14:11]), adjust(shifted[10:7])};
        bin_next     = shifted[6:0];
        digits_valid = (tens_in <= 4'd9) && (ones_in <= 4'd9);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            bcd_sr     <= 8'd0;
            bin_sr     <= 7'd0;
            iter_cnt   <= 3'd0;
            done       <= 1'b0;
            error      <= 1'b0;
            binary_out <= 7'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        if (digits_valid) begin
                            bcd_sr   <= {tens_in, ones_in};
                            bin_sr   <= 7'd0;
                            iter_cnt <= 3'd0;
                            error    <= 1'b0;
                            state    <= SHIFT;
                        end else begin
                            error      <= 1'b1;
                            binary_out <= 7'd0;
                            done       <= 1'b1;
                            state      <= DONE;
                        end
                    end
                end
                SHIFT: begin
                    bcd_sr   <= bcd_adj;
                    bin_sr   <= bin_next;
                    iter_cnt <= iter_cnt + 3'd1;
                    if (iter_cnt == LAST_ITER) begin
                        binary_out <= bin_next;
                        done       <= 1'b1;
                        state      <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    done  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_bcd_binary_serial.sv
// Directed-vector bench for bcd_binary_serial: handshake timing, all 100 decimal inputs,
// digit errors, start ignored while busy, and asynchronous reset mid-conversion.
module tb_bcd_binary_serial;

    logic       clk;
    logic       reset;
    logic       start;
    logic [3:0] tens_in;
    logic [3:0] ones_in;
    logic       busy;
    logic       done;
    logic       error;
    logic [6:0] binary_out;

    int compared;
    int mismatched;

    bcd_binary_serial dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .tens_in   (tens_in),
        .ones_in   (ones_in),
        .busy      (busy),
        .done      (done),
        .error     (error),
        .binary_out(binary_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input int observed, input int expected);
        compared++;
        if (observed != expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Present one request; E0 is the accepting edge, checks land 1 time unit after each edge.
    task automatic applyStimulus(input logic [3:0] t, input logic [3:0] o,
                                 input int expected, input bit expect_err, input string tag);
        int cyc;
        @(negedge clk);
        start   = 1'b1;
        tens_in = t;
        ones_in = o;
        @(posedge clk);
        #1;
        start   = 1'b0;
        tens_in = 4'hF;
        ones_in = 4'hE;
        if (expect_err) begin
            checkOutput({tag, " err_done"}, done, 1);
            checkOutput({tag, " err_flag"}, error, 1);
            checkOutput({tag, " err_value"}, binary_out, 0);
            checkOutput({tag, " err_busy"}, busy, 1);
            @(posedge clk);
            #1;
            checkOutput({tag, " err_done_fall"}, done, 0);
            checkOutput({tag, " err_busy_fall"}, busy, 0);
            checkOutput({tag, " err_held"}, error, 1);
        end else begin
            checkOutput({tag, " e0_busy"}, busy, 1);
            checkOutput({tag, " e0_error"}, error, 0);
            checkOutput({tag, " e0_done"}, done, 0);
            cyc = 0;
            while (!done && cyc < 20) begin
                @(posedge clk);
                #1;
                cyc++;
            end
            checkOutput({tag, " latency"}, cyc, 7);
            checkOutput({tag, " value"}, binary_out, expected);
            @(posedge clk);
            #1;
            checkOutput({tag, " done_fall"}, done, 0);
            checkOutput({tag, " busy_fall"}, busy, 0);
            checkOutput({tag, " value_held"}, binary_out, expected);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached, got timeout, expected finish");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        start      = 1'b0;
        tens_in    = 4'd0;
        ones_in    = 4'd0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset busy", busy, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset error", error, 0);
        checkOutput("reset value", binary_out, 0);
        @(negedge clk);
        reset = 1'b0;

        applyStimulus(4'd0, 4'd0, 0, 1'b0, "00");
        applyStimulus(4'd9, 4'd9, 99, 1'b0, "99");

        // Every decimal value, digits derived from the binary value (round trip).
        for (int v = 0; v < 100; v++) begin
            applyStimulus(4'(v / 10), 4'(v % 10), v, 1'b0, $sformatf("sweep%0d", v));
        end

        applyStimulus(4'hA, 4'd3, 0, 1'b1, "A3");
        applyStimulus(4'd2, 4'hF, 0, 1'b1, "2F");
        applyStimulus(4'd4, 4'd2, 42, 1'b0, "42 after error");

        // 5,7 accepted; start toggled with 1,1 while shifting must be ignored.
        @(negedge clk);
        start   = 1'b1;
        tens_in = 4'd5;
        ones_in = 4'd7;
        @(posedge clk);
        #1;
        checkOutput("57 e0_busy", busy, 1);
        for (int i = 1; i <= 7; i++) begin
            @(negedge clk);
            start   = i[0];
            tens_in = 4'd1;
            ones_in = 4'd1;
            @(posedge clk);
            #1;
            if (i < 7) begin
                checkOutput($sformatf("57 mid_value_e%0d", i), binary_out, 42);
                checkOutput($sformatf("57 mid_done_e%0d", i), done, 0);
            end else begin
                checkOutput("57 done", done, 1);
                checkOutput("57 value", binary_out, 57);
            end
        end
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #1;
        checkOutput("57 done_fall", done, 0);
        checkOutput("57 busy_fall", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("57 no_requeue", busy, 0);

        // start held high: second conversion accepted after one IDLE cycle.
        @(negedge clk);
        start   = 1'b1;
        tens_in = 4'd2;
        ones_in = 4'd5;
        @(posedge clk);
        repeat (7) @(posedge clk);
        #1;
        checkOutput("held first_done", done, 1);
        checkOutput("held first_value", binary_out, 25);
        @(posedge clk);
        #1;
        checkOutput("held idle_gap", busy, 0);
        @(posedge clk);
        #1;
        checkOutput("held retrigger", busy, 1);
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1;
        checkOutput("held second_done", done, 1);
        checkOutput("held second_value", binary_out, 25);
        @(posedge clk);
        #1;

        // 8,6 aborted by reset between E3 and E4.
        @(negedge clk);
        start   = 1'b1;
        tens_in = 4'd8;
        ones_in = 4'd6;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("abort busy", busy, 0);
        checkOutput("abort done", done, 0);
        checkOutput("abort error", error, 0);
        checkOutput("abort value", binary_out, 0);
        @(negedge clk);
        reset = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        checkOutput("abort no_done", done, 0);
        checkOutput("abort value_still0", binary_out, 0);
        applyStimulus(4'd3, 4'd8, 38, 1'b0, "38 after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
